// File: rtl/uart_baud_gen_frac.sv
// uart_baud_gen_frac
//   Runtime-programmable fractional baud-rate generator. A down-counter
//   produces one os_tick every act_int (+1 on fractional carry) clocks, and
//   every OVERSAMPLE-th os_tick is also a bit_tick. A new divisor is taken
//   over a valid/ready handshake and only applied at a period boundary,
//   so no tick interval is ever cut short.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   en         run enable; low holds the counter at a full period
//   cfg_valid  a new divisor is offered
//   cfg_int    integer clocks per os_tick (values below 2 are stored as 2)
//   cfg_frac   fractional clocks per os_tick, units of 2^-FRAC_W
//   cfg_ready  an update can be accepted
//   os_tick    oversample enable, one cycle wide
//   bit_tick   bit enable, coincident with every OVERSAMPLE-th os_tick
//   cur_div    active divisor as {int, frac}
module uart_baud_gen_frac #(
   parameter int CLOCK_RATE = 100_000_000,
   parameter int BAUD_RATE  = 57_600,
   parameter int OVERSAMPLE = 16,
   parameter int INT_W      = 16,
   parameter int FRAC_W     = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    cfg_valid,
   input  logic [INT_W-1:0]        cfg_int,
   input  logic [FRAC_W-1:0]       cfg_frac,
   output logic                    cfg_ready,
   output logic                    os_tick,
   output logic                    bit_tick,
   output logic [INT_W+FRAC_W-1:0] cur_div
);

   localparam int PH_W = $clog2(OVERSAMPLE);

   // Reset divisor, rounded to the nearest 2^-FRAC_W clock.
   localparam logic [63:0] CLK64 = 64'(CLOCK_RATE);
   localparam logic [63:0] DEN   = 64'(OVERSAMPLE) * 64'(BAUD_RATE);
   localparam logic [63:0] DEF   = ((CLK64 << FRAC_W) + (DEN >> 1)) / DEN;
   localparam logic [INT_W-1:0]  DEF_INT  = DEF[FRAC_W +: INT_W];
   localparam logic [FRAC_W-1:0] DEF_FRAC = DEF[FRAC_W-1:0];

   // An integer divisor below 2 would give back-to-back or stuck ticks.
   function automatic logic [INT_W-1:0] clamp_int(input logic [INT_W-1:0] v);
      return (v < INT_W'(2)) ? INT_W'(2) : v;
   endfunction

   logic [INT_W-1:0]  cnt;
   logic [FRAC_W-1:0] acc;
   logic [PH_W-1:0]   phase;
   logic [INT_W-1:0]  act_int;
   logic [FRAC_W-1:0] act_frac;
   logic [INT_W-1:0]  pend_int;
   logic [FRAC_W-1:0] pend_frac;
   logic              pend;

   logic              tc;
   logic              xfer;
   logic              apply;
   logic [FRAC_W:0]   acc_sum;

   assign tc      = (cnt == '0);
   assign xfer    = cfg_valid & cfg_ready;
   // A pending divisor lands on a period boundary, or at once when idle.
   assign apply   = pend & (~en | tc);
   assign acc_sum = {1'b0, acc} + {1'b0, act_frac};
   assign cur_div = {act_int, act_frac};

   // ---- period counter, fractional accumulator and tick registers ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= DEF_INT - INT_W'(1);
         acc       <= '0;
         phase     <= '0;
         act_int   <= DEF_INT;
         act_frac  <= DEF_FRAC;
         pend_int  <= '0;
         pend_frac <= '0;
         pend      <= 1'b0;
         cfg_ready <= 1'b1;
         os_tick   <= 1'b0;
         bit_tick  <= 1'b0;
      end else begin
         if (xfer) begin
            pend      <= 1'b1;
            pend_int  <= clamp_int(cfg_int);
            pend_frac <= cfg_frac;
         end else if (apply) begin
            pend <= 1'b0;
         end

         // Ready stays low through the apply cycle and returns one edge later.
         cfg_ready <= ~(pend | xfer);

         os_tick  <= en & tc;
         bit_tick <= en & tc & (phase == PH_W'(OVERSAMPLE - 1));

         if (apply) begin
            act_int  <= pend_int;
            act_frac <= pend_frac;
            acc      <= '0;
            cnt      <= pend_int - INT_W'(1);
         end else if (!en) begin
            acc <= '0;
            cnt <= act_int - INT_W'(1);
         end else if (tc) begin
            // Carry out of the fraction stretches the next period by one clock.
            acc <= acc_sum[FRAC_W-1:0];
            cnt <= act_int - INT_W'(1) + INT_W'(acc_sum[FRAC_W]);
         end else begin
            cnt <= cnt - INT_W'(1);
         end

         if (!en) begin
            phase <= '0;
         end else if (tc) begin
            phase <= phase + PH_W'(1);
         end
      end
   end

endmodule
